// File: rtl/run_control_if.sv
// run_control_if: front-panel buttons, CPU halt request and run-control outputs
interface run_control_if #(
  parameter int CYC_WIDTH = 32
);
  logic start;
  logic interrupt;
  logic step;
  logic halted;
  logic cpu_ce;
  logic cpu_rst;
  logic pix_ce;
  logic ready;
  logic busy;
  logic interrupted;
  logic stopped;
  logic [CYC_WIDTH-1:0] cycles;
  modport master (
    output start, interrupt, step, halted,
    input cpu_ce, cpu_rst, pix_ce, ready, busy, interrupted, stopped, cycles
  );
  modport slave (
    input start, interrupt, step, halted,
    output cpu_ce, cpu_rst, pix_ce, ready, busy, interrupted, stopped, cycles
  );
endinterface

// File: rtl/run_control.sv
// run_control: button-driven IDLE/RUN/PAUSED/HALTED sequencer issuing CPU and pixel clock enables
module run_control #(
  parameter int DIV_MAX   = 2097151,
  parameter int DIV_WIDTH = 21,
  parameter int PIX_DIV   = 2,
  parameter int CYC_WIDTH = 32
) (
  input logic fpgaclock,
  input logic reset,
  run_control_if.slave bus
);
  localparam int PW = $clog2(PIX_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, HALTED} state_t;
  state_t state, nxt;
  logic [2:0] s1, s2, s3, ev;
  logic [DIV_WIDTH-1:0] div;
  logic [PW-1:0] pix;
  logic wrap, pix_end, step_ce, ce;
  assign ev = s2 & ~s3;
  assign wrap = div == DIV_WIDTH'(DIV_MAX);
  assign pix_end = pix == PW'(PIX_DIV - 1);
  // next state with interrupt over halt over start/step; ev = {step, interrupt, start}
  always_comb begin
    nxt = state;
    step_ce = 1'b0;
    unique case (state)
      IDLE:    nxt = ev[0] ? RUN : IDLE;
      RUN:     nxt = ev[1] ? PAUSED : bus.halted ? HALTED : RUN;
      PAUSED: begin
        nxt = ev[1] ? RUN : PAUSED;
        step_ce = ~ev[1] & ev[2];
      end
      HALTED: begin
        nxt = ev[0] ? RUN : HALTED;
        step_ce = ~ev[0] & ev[2];
      end
    endcase
    ce = (wrap && state == RUN && nxt == RUN) || step_ce;
  end
  // synchronisers, free-running dividers, state and registered outputs
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      {s1, s2, s3} <= '0;
      div <= '0;
      pix <= '0;
      state <= IDLE;
      bus.cpu_ce <= 1'b0;
      bus.pix_ce <= 1'b0;
      bus.cycles <= '0;
      bus.ready <= 1'b1;
      bus.cpu_rst <= 1'b1;
      bus.busy <= 1'b0;
      bus.interrupted <= 1'b0;
      bus.stopped <= 1'b0;
    end else begin
      s1 <= {bus.step, bus.interrupt, bus.start};
      s2 <= s1;
      s3 <= s2;
      div <= wrap ? '0 : div + DIV_WIDTH'(1);
      pix <= pix_end ? '0 : pix + PW'(1);
      state <= nxt;
      bus.cpu_ce <= ce;
      bus.pix_ce <= pix_end;
      bus.cycles <= state == IDLE ? '0 : bus.cycles + CYC_WIDTH'(ce);
      bus.ready <= nxt == IDLE;
      bus.cpu_rst <= nxt == IDLE;
      bus.busy <= nxt == RUN;
      bus.interrupted <= nxt == PAUSED;
      bus.stopped <= nxt == HALTED;
    end
  end
endmodule

// File: tb/tb_run_control.sv
// tb_run_control: random and scripted button traffic checked against a time-indexed reference model
module tb_run_control;
  localparam int DM = 3;
  localparam int PD = 2;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  run_control_if #(.CYC_WIDTH(CW)) bus ();
  run_control #(.DIV_MAX(DM), .DIV_WIDTH(2), .PIX_DIV(PD), .CYC_WIDTH(CW)) dut (
    .fpgaclock(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  int t = 0;
  int ms = 0;
  int e_cyc = 0;
  bit e_ce = 0;
  bit e_pix = 0;
  bit [2:0] lv[$];
  function automatic bit [2:0] lvl(input int e);
    return (e >= 1 && e <= lv.size()) ? lv[e-1] : 3'b000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input bit r, input bit [2:0] b, input bit h);
    bit [2:0] ev;
    bit wrap, stp;
    int ns;
    if (r) begin
      t = 0; lv.delete(); ms = 0; e_cyc = 0; e_ce = 0; e_pix = 0;
      return;
    end
    t++;
    lv.push_back(b);
    ev = lvl(t - 2) & ~lvl(t - 3);
    wrap = ((t - 1) % (DM + 1)) == DM;
    ns = ms;
    stp = 0;
    if (ms == 0 && ev[0]) ns = 1;
    else if (ms == 1) ns = ev[1] ? 2 : h ? 3 : 1;
    else if (ms == 2) begin
      if (ev[1]) ns = 1; else stp = ev[2];
    end else if (ms == 3) begin
      if (ev[0]) ns = 1; else stp = ev[2];
    end
    e_ce = (wrap && ms == 1 && ns == 1) || stp;
    e_cyc = ms == 0 ? 0 : (e_cyc + int'(e_ce)) % (1 << CW);
    e_pix = ((t - 1) % PD) == PD - 1;
    ms = ns;
  endtask
  task automatic cyc(input bit r, input bit [2:0] b, input bit h);
    @(negedge clk);
    reset = r;
    bus.start = b[0];
    bus.interrupt = b[1];
    bus.step = b[2];
    bus.halted = h;
    @(posedge clk);
    model(r, b, h);
    #1;
    chk("cpu_ce", 32'(bus.cpu_ce), 32'(e_ce));
    chk("pix_ce", 32'(bus.pix_ce), 32'(e_pix));
    chk("cycles", 32'(bus.cycles), 32'(e_cyc));
    chk("status", 32'({bus.ready, bus.busy, bus.interrupted, bus.stopped, bus.cpu_rst}),
        32'({ms == 0, ms == 1, ms == 2, ms == 3, ms == 0}));
  endtask
  task automatic press(input int btn, input int hold, input int gap);
    for (int i = 0; i < hold; i++) cyc(0, 3'(1 << btn), 0);
    for (int i = 0; i < gap; i++) cyc(0, 3'b000, 0);
  endtask
  initial begin
    bit [2:0] b;
    bit h;
    bus.start = 0; bus.interrupt = 0; bus.step = 0; bus.halted = 0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    press(0, 3, 14);
    press(1, 20, 10);
    for (int i = 0; i < 3; i++) press(2, 2, 3);
    press(1, 1, 9);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1);
    press(2, 1, 4);
    press(0, 1, 8);
    cyc(1, 0, 0);
    press(0, 1, 80);
    b = 0;
    h = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(7) == 0) b[k] = ~b[k];
      h = $urandom_range(15) == 0;
      cyc($urandom_range(299) == 0, b, h);
    end
    cyc(1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/run_control.md
# run_control

Parametrised run controller for the basic computer: it replaces the fixed 21-bit clock slow-down and the ready/busy/interrupted control with a single-clock block. The block synchronises and edge-detects the front-panel buttons and sequences IDLE/RUN/PAUSED/HALTED states. It issues one-cycle clock-enable pulses to the CPU and the VGA path, with no gated clocks. It adds single-step, resume-after-halt, and a CPU cycle counter. It sits between the board top level and `main`.

## Interface
- `DIV_MAX`, 2097151: CPU tick period minus one, in `fpgaclock` cycles (DIV_MAX+1 cycles per tick); ≥1.
- `DIV_WIDTH`, 21: divider counter width; must hold DIV_MAX.
- `PIX_DIV`, 2: pixel enable period in `fpgaclock` cycles; ≥2.
- `CYC_WIDTH`, 32: width of executed-cycle counter.

Ports:
- `fpgaclock` in 1: sole clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: button, asynchronous level.
- `interrupt` in 1: button, asynchronous level.
- `step` in 1: button, asynchronous level.
- `halted` in 1: CPU halt request, `fpgaclock` domain, level.
- `cpu_ce` out 1: one-cycle CPU clock enable.
- `cpu_rst` out 1: holds `main` in reset.
- `pix_ce` out 1: VGA pixel enable.
- `ready` out 1: state is IDLE.
- `busy` out 1: state is RUN.
- `interrupted` out 1: state is PAUSED.
- `stopped` out 1: state is HALTED.
- `cycles` out CYC_WIDTH: count of `cpu_ce` pulses since leaving IDLE.

## Operation
- Buttons pass through a 2-flop synchroniser, then a rising-edge detector. Each press yields exactly one event pulse, however long the button is held.
- Event priority within a cycle: `reset` > interrupt > `halted` > start/step.
- States and transitions:
  - IDLE: start → RUN.
  - RUN: interrupt → PAUSED; `halted`=1 → HALTED.
  - PAUSED: interrupt → RUN; step → PAUSED, with exactly one `cpu_ce`; start is ignored.
  - HALTED: start → RUN (resume); step → one `cpu_ce`, stays HALTED.
  - `reset` in any state → IDLE.
- There is no return to IDLE except `reset`.
- `cpu_rst` = 1 exactly while in IDLE.
- `cycles` is cleared while in IDLE and increments on every `cpu_ce`, including step pulses. It wraps modulo 2^CYC_WIDTH.
- Divider:
  - Free-running in all states; it counts 0..DIV_MAX and wraps to 0.
  - Cleared by `reset`.
  - Not reset by state changes.
- `cpu_ce` (registered) is asserted for the cycle after the edge at which both hold:
  - the divider equals DIV_MAX;
  - the state is RUN and stays RUN across that edge.
- A step `cpu_ce` is registered and is asserted for one cycle, independent of divider phase.
- A tick and a step never coincide: steps exist only outside RUN.
- `pix_ce` comes from an independent counter 0..PIX_DIV-1. It is high for one cycle per period, runs in all states, and is cleared by `reset`.

## Timing
- Reset values:
  - state IDLE; `ready`=1, `cpu_rst`=1;
  - `busy`=`interrupted`=`stopped`=0;
  - `cpu_ce`=`pix_ce`=0; `cycles`=0;
  - divider and pixel counter 0.
- Button latency: a level first sampled high at edge k changes state at edge k+2. A step's `cpu_ce` is high during the cycle after edge k+2.
- `halted` is unsynchronised. If high before edge k while in RUN, HALTED is entered at edge k, and no `cpu_ce` is produced by a wrap at edge k.
- Interrupt and halt at the same edge → PAUSED. The later resume re-evaluates `halted` at the next edge.
- Resume from PAUSED or HALTED keeps the divider phase. The first tick comes at the next wrap, not after a full period.
- `reset` mid-run: `cpu_ce` is 0 in the following cycle, and a pending step is discarded.
- Status outputs are registered and decode the current state only: exactly one of ready/busy/interrupted/stopped is 1.

## Test plan
- Reset then 1 press of start (DIV_MAX=3, PIX_DIV=2) → ready 1→0 and busy=1 at press+2 edges. After that, `cpu_ce` is high 1 cycle in every 4, `pix_ce` alternates, and `cycles` counts 1,2,3…
- Hold interrupt 20 cycles while in RUN → exactly one transition to PAUSED, then no `cpu_ce`. A second press → RUN; the first tick aligns to the prior divider phase.
- In PAUSED, 3 step presses → exactly 3 single-cycle `cpu_ce` pulses, `cycles` +3, state stays PAUSED.
- `halted`=1 in RUN at the edge where the divider equals DIV_MAX → `stopped`=1 and no `cpu_ce`. Start → RUN, `stopped`=0.
- Interrupt event and `halted` at the same edge → `interrupted`=1, `stopped`=0. With CYC_WIDTH=4, 17 ticks → `cycles`=1.
- `reset` during RUN → next cycle `ready`=1, `cpu_rst`=1, `cycles`=0, `cpu_ce`=0, counters 0.
